// File: rtl/data_mem_sync_hs.sv
// Clocked data memory with byte-lane writes, a valid/ready request channel and a
// registered, back-pressurable read-response channel; zero-fills itself after reset.
module data_mem_sync_hs #(
    parameter int data_mem_length = 8,
    parameter int data_mem_width  = 8,
    parameter int INIT_ON_RESET   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [data_mem_length-1:0]    req_addr,
    input  logic [data_mem_width-1:0]     req_wdata,
    input  logic [data_mem_width/8-1:0]   req_be,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [data_mem_width-1:0]     rsp_rdata,
    output logic                          init_done,
    output logic                          dbg_state
);
    localparam int NB    = data_mem_width / 8;
    localparam int DEPTH = 2 ** data_mem_length;
    localparam int SW    = data_mem_length + 1;

    // Handshake: a request transfers on a rising edge where req_valid & req_ready;
    // a response transfers where rsp_valid & rsp_ready, and is held stable until then.

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                      state_q, state_d;
    logic [SW-1:0]               sweep_q, sweep_d;
    logic                        init_done_q, init_done_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [data_mem_width-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [data_mem_width-1:0]   mem_q [DEPTH];
    logic [NB-1:0]               mem_we;
    logic [data_mem_length-1:0]  mem_waddr;
    logic [data_mem_width-1:0]   mem_wdata;
    logic                        accept;

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        init_done_d = init_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_we      = '0;
        mem_waddr   = req_addr;
        mem_wdata   = req_wdata;
        req_ready   = 1'b0;
        accept      = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (INIT_ON_RESET != 0) begin
                    mem_we    = {NB{1'b1}};
                    mem_waddr = sweep_q[data_mem_length-1:0];
                    mem_wdata = '0;
                    sweep_d   = sweep_q + SW'(1);
                    // Carry into the extra bit marks the write of the last address.
                    if (sweep_d[data_mem_length]) begin
                        state_d     = ST_RUN;
                        init_done_d = 1'b1;
                    end
                end else begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                req_ready = !rsp_valid_q || rsp_ready;
                accept    = req_valid && req_ready;
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
                if (accept) begin
                    if (req_we) begin
                        mem_we = req_be;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = mem_q[req_addr];
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // The array is never reset; it is only cleared by the sweep.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_we[i]) begin
                    mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;
    assign dbg_state = (state_q == ST_RUN);

endmodule
